seq_core_debug_cmd_responder: RTL and testbench

- Hardware responder for the sequencer core debug command mailbox.
- An Avalon-MM slave gives the host (Nios/JTAG master) access to the debug registers at SEQ_CORE_DEBUG_BASE: REQ_CMD at +0x8, CMD_STATUS at +0xC, CMD_PARAMS from +0x10.
- Accepted commands go to the sequencer core over a valid/ready handshake; the core's response is collected, with timeout and error reporting, and published in CMD_STATUS.
- Address decode against SEQ_CORE_DEBUG_BASE is done upstream; this block sees word offsets only.

---
 rtl/seq_core_debug_rsp_pkg.sv | 50 +++++
 rtl/seq_core_debug_timeout_ctr.sv | 35 +++
 rtl/seq_core_debug_cmd_responder.sv | 162 ++++++++++++++++
 tb/tb_seq_core_debug_cmd_responder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_core_debug_rsp_pkg.sv
// Shared definitions for the sequencer core debug command responder:
// FSM states, error codes, register word offsets and CMD_STATUS layout.
package seq_core_debug_rsp_pkg;

  localparam logic [31:0] SEQ_CORE_DEBUG_BASE      = 32'h0000_0000;
  localparam logic [31:0] SEQ_CORE_DEBUG_SIZE_REG  = SEQ_CORE_DEBUG_BASE + 32'h0;
  localparam logic [31:0] SEQ_CORE_RSP_DATA        = SEQ_CORE_DEBUG_BASE + 32'h4;
  localparam logic [31:0] SEQ_CORE_REQ_CMD         = SEQ_CORE_DEBUG_BASE + 32'h8;
  localparam logic [31:0] SEQ_CORE_CMD_STATUS      = SEQ_CORE_DEBUG_BASE + 32'hC;
  localparam logic [31:0] SEQ_CORE_CMD_PARAMS      = SEQ_CORE_DEBUG_BASE + 32'h10;

  localparam logic [3:0] OfsDebugSize = 4'((SEQ_CORE_DEBUG_SIZE_REG - SEQ_CORE_DEBUG_BASE) >> 2);
  localparam logic [3:0] OfsRspData   = 4'((SEQ_CORE_RSP_DATA - SEQ_CORE_DEBUG_BASE) >> 2);
  localparam logic [3:0] OfsReqCmd    = 4'((SEQ_CORE_REQ_CMD - SEQ_CORE_DEBUG_BASE) >> 2);
  localparam logic [3:0] OfsCmdStatus = 4'((SEQ_CORE_CMD_STATUS - SEQ_CORE_DEBUG_BASE) >> 2);
  localparam logic [3:0] OfsParams    = 4'((SEQ_CORE_CMD_PARAMS - SEQ_CORE_DEBUG_BASE) >> 2);

  typedef enum logic [2:0] {StIdle, StIssue, StWaitRsp, StDone, StError} state_e;

  localparam logic [3:0] ErrNone    = 4'd0;
  localparam logic [3:0] ErrBadCmd  = 4'd1;
  localparam logic [3:0] ErrTimeout = 4'd2;
  localparam logic [3:0] ErrCoreErr = 4'd3;

  localparam int unsigned StatStateLsb = 0;
  localparam int unsigned StatErrLsb   = 4;
  localparam int unsigned StatRspLsb   = 8;
  localparam int unsigned StatDropLsb  = 16;

  function automatic logic [1:0] status_state(state_e s);
    case (s)
      StIssue, StWaitRsp: return 2'd1;
      StDone:             return 2'd2;
      StError:            return 2'd3;
      default:            return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] pack_status(logic [1:0] st, logic [3:0] err,
                                              logic [7:0] rspc, logic [15:0] drop);
    logic [31:0] s;
    s = '0;
    s[StatStateLsb +: 2] = st;
    s[StatErrLsb +: 4]   = err;
    s[StatRspLsb +: 8]   = rspc;
    s[StatDropLsb +: 16] = drop;
    return s;
  endfunction

endpackage

// File: rtl/seq_core_debug_timeout_ctr.sv
// Loadable down-counter; flags expiry on the enabled cycle that would bring it to zero.
module seq_core_debug_timeout_ctr #(
  parameter int unsigned       Width   = 16,
  parameter logic [Width-1:0] LoadVal = '1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // A zero load value never reaches one, so the timeout is disabled.
  assign expire_o = en_i && !load_i && (cnt_q == Width'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_core_debug_cmd_responder.sv
// Debug command mailbox: Avalon-MM register file that issues commands to the sequencer
// core over valid/ready and publishes the response, timeout and errors in CMD_STATUS.
module seq_core_debug_cmd_responder
  import seq_core_debug_rsp_pkg::*;
#(
  parameter int unsigned NUM_PARAMS     = 4,
  parameter int unsigned NUM_CMDS       = 22,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [31:0] DEBUG_SIZE     = 32'h8f4
) (
  input  logic                    avl_clk,
  input  logic                    avl_reset,
  input  logic [3:0]              avl_address,
  input  logic                    avl_write,
  input  logic [31:0]             avl_writedata,
  input  logic                    avl_read,
  output logic [31:0]             avl_readdata,
  output logic                    avl_readdatavalid,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [7:0]              cmd_code,
  output logic [32*NUM_PARAMS-1:0] cmd_params,
  input  logic                    rsp_valid,
  input  logic [7:0]              rsp_code,
  input  logic [31:0]             rsp_data,
  output logic                    busy
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_e                         state_q, state_d;
  logic [7:0]                     code_q, code_d;
  logic [NUM_PARAMS-1:0][31:0]    params_q, params_d;
  logic [31:0]                    rsp_data_q, rsp_data_d;
  logic [3:0]                     err_q, err_d;
  logic [7:0]                     rspc_q, rspc_d;
  logic [15:0]                    drop_q, drop_d;
  logic [31:0]                    readdata_q, readdata_d;
  logic                           rdv_q, cmd_valid_q, cmd_valid_d, busy_q, busy_d;
  logic                           req_wr, timer_load, timer_en, timer_expire;
  logic [31:0]                    rd_mux;

  assign req_wr     = avl_write && (avl_address == OfsReqCmd);
  assign timer_load = (state_q == StIssue) && cmd_ready;
  assign timer_en   = (state_q == StWaitRsp) && !rsp_valid;

  seq_core_debug_timeout_ctr #(
    .Width   (TimerW),
    .LoadVal (TimerW'(TIMEOUT_CYCLES))
  ) u_timeout_ctr (
    .clk_i    (avl_clk),
    .rst_i    (avl_reset),
    .load_i   (timer_load),
    .en_i     (timer_en),
    .expire_o (timer_expire)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    params_d   = params_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    rspc_d     = rspc_q;
    drop_d     = drop_q;
    case (state_q)
      StIdle, StDone, StError: begin
        if (req_wr) begin
          if (avl_writedata != '0) begin
            code_d = avl_writedata[7:0];
            err_d  = ErrNone;
            rspc_d = '0;
            if ((avl_writedata[7:0] == 8'd0) || ({24'd0, avl_writedata[7:0]} >= NUM_CMDS)) begin
              state_d = StError;
              err_d   = ErrBadCmd;
            end else begin
              state_d = StIssue;
            end
          end else if (state_q != StIdle) begin
            state_d = StIdle;
            err_d   = ErrNone;
            rspc_d  = '0;
          end
        end
        for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
          if (avl_write && (avl_address == OfsParams + 4'(i))) params_d[i] = avl_writedata;
        end
      end
      StIssue, StWaitRsp: begin
        if (req_wr && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        if (state_q == StIssue) begin
          if (cmd_ready) state_d = StWaitRsp;
        end else if (rsp_valid) begin
          rsp_data_d = rsp_data;
          rspc_d     = rsp_code;
          if (rsp_code == 8'd0) begin
            state_d = StDone;
          end else begin
            state_d = StError;
            err_d   = ErrCoreErr;
          end
        end else if (timer_expire) begin
          state_d = StError;
          err_d   = ErrTimeout;
        end
      end
      default: state_d = StIdle;
    endcase
    cmd_valid_d = (state_d == StIssue);
    busy_d      = (state_d == StIssue) || (state_d == StWaitRsp);
  end

  // Read data reflects register contents before this cycle's update.
  always_comb begin
    rd_mux = '0;
    if (avl_address == OfsDebugSize) rd_mux = DEBUG_SIZE;
    if (avl_address == OfsRspData)   rd_mux = rsp_data_q;
    if (avl_address == OfsReqCmd)    rd_mux = {24'd0, code_q};
    if (avl_address == OfsCmdStatus) rd_mux = pack_status(status_state(state_q), err_q, rspc_q,
                                                          drop_q);
    for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
      if (avl_address == OfsParams + 4'(i)) rd_mux = params_q[i];
    end
    readdata_d = avl_read ? rd_mux : readdata_q;
  end

  always_ff @(posedge avl_clk or posedge avl_reset) begin
    if (avl_reset) begin
      state_q     <= StIdle;
      code_q      <= '0;
      params_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= ErrNone;
      rspc_q      <= '0;
      drop_q      <= '0;
      readdata_q  <= '0;
      rdv_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      params_q    <= params_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
      rspc_q      <= rspc_d;
      drop_q      <= drop_d;
      readdata_q  <= readdata_d;
      rdv_q       <= avl_read;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign avl_readdata      = readdata_q;
  assign avl_readdatavalid = rdv_q;
  assign cmd_valid         = cmd_valid_q;
  assign cmd_code          = code_q;
  assign cmd_params        = params_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_seq_core_debug_cmd_responder.sv
// Self-checking bench: directed mailbox scenarios plus random traffic against a
// transaction-level reference model of the debug command responder.
module tb_seq_core_debug_cmd_responder;

  localparam int unsigned NP = 4;
  localparam int unsigned NC = 22;
  localparam int unsigned TO = 16;

  localparam int MIdle = 0, MIssue = 1, MWait = 2, MDone = 3, MErr = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        avl_address = '0;
  logic              avl_write = 1'b0;
  logic [31:0]       avl_writedata = '0;
  logic              avl_read = 1'b0;
  logic [31:0]       avl_readdata;
  logic              avl_readdatavalid;
  logic              cmd_valid;
  logic              cmd_ready = 1'b0;
  logic [7:0]        cmd_code;
  logic [32*NP-1:0]  cmd_params;
  logic              rsp_valid = 1'b0;
  logic [7:0]        rsp_code = '0;
  logic [31:0]       rsp_data = '0;
  logic              busy;

  always #5 clk = ~clk;

  seq_core_debug_cmd_responder #(
    .NUM_PARAMS     (NP),
    .NUM_CMDS       (NC),
    .TIMEOUT_CYCLES (TO),
    .DEBUG_SIZE     (32'h8f4)
  ) dut (
    .avl_clk           (clk),
    .avl_reset         (rst),
    .avl_address       (avl_address),
    .avl_write         (avl_write),
    .avl_writedata     (avl_writedata),
    .avl_read          (avl_read),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_code          (cmd_code),
    .cmd_params        (cmd_params),
    .rsp_valid         (rsp_valid),
    .rsp_code          (rsp_code),
    .rsp_data          (rsp_data),
    .busy              (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: mailbox mode, registers and remaining timeout budget.
  int          m_mode, m_err, m_drop, m_left;
  logic [7:0]  m_code, m_rspc;
  logic [31:0] m_par [NP];
  logic [31:0] m_rspd, m_rdd;
  logic        m_rdv;

  function automatic void model_reset();
    m_mode = MIdle; m_err = 0; m_drop = 0; m_left = 0;
    m_code = '0; m_rspc = '0; m_rspd = '0; m_rdd = '0; m_rdv = 1'b0;
    for (int i = 0; i < NP; i++) m_par[i] = '0;
  endfunction

  function automatic logic [31:0] m_reg(input int a);
    int st;
    st = (m_mode == MIssue || m_mode == MWait) ? 1 : (m_mode == MDone) ? 2 :
         (m_mode == MErr) ? 3 : 0;
    if (a == 0) return 32'h8f4;
    if (a == 1) return m_rspd;
    if (a == 2) return {24'd0, m_code};
    if (a == 3) return (32'(m_drop) << 16) | ({24'd0, m_rspc} << 8) | (32'(m_err) << 4) | 32'(st);
    if (a >= 4 && a < 4 + NP) return m_par[a-4];
    return 32'd0;
  endfunction

  function automatic void model_step();
    int a, nmode;
    bit mb;
    a     = int'(avl_address);
    nmode = m_mode;
    mb    = (m_mode == MIssue) || (m_mode == MWait);
    m_rdv = avl_read;
    if (avl_read) m_rdd = m_reg(a);
    if (avl_write && a == 2) begin
      if (mb) begin
        if (m_drop < 65535) m_drop++;
      end else if (avl_writedata != 0) begin
        m_code = avl_writedata[7:0];
        m_err = 0;
        m_rspc = '0;
        if (m_code == 0 || int'(m_code) >= NC) begin nmode = MErr; m_err = 1; end
        else nmode = MIssue;
      end else if (m_mode != MIdle) begin
        nmode = MIdle; m_err = 0; m_rspc = '0;
      end
    end
    if (avl_write && !mb && a >= 4 && a < 4 + NP) m_par[a-4] = avl_writedata;
    if (m_mode == MIssue && cmd_ready) begin nmode = MWait; m_left = TO; end
    if (m_mode == MWait) begin
      if (rsp_valid) begin
        m_rspd = rsp_data;
        m_rspc = rsp_code;
        if (rsp_code == 0) nmode = MDone;
        else begin nmode = MErr; m_err = 3; end
      end else begin
        m_left--;
        if (m_left == 0) begin nmode = MErr; m_err = 2; end
      end
    end
    m_mode = nmode;
  endfunction

  task automatic check_outputs();
    logic [32*NP-1:0] exp_par;
    for (int i = 0; i < NP; i++) exp_par[32*i +: 32] = m_par[i];
    check_eq("cmd_valid", 128'(cmd_valid), 128'(m_mode == MIssue));
    check_eq("busy", 128'(busy), 128'(m_mode == MIssue || m_mode == MWait));
    check_eq("cmd_code", 128'(cmd_code), 128'(m_code));
    check_eq("cmd_params", 128'(cmd_params), 128'(exp_par));
    check_eq("readdatavalid", 128'(avl_readdatavalid), 128'(m_rdv));
    if (m_rdv) check_eq("readdata", 128'(avl_readdata), 128'(m_rdd));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    avl_write = 1'b1; avl_address = a; avl_writedata = d;
    step();
    avl_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    avl_read = 1'b1; avl_address = a;
    step();
    avl_read = 1'b0;
    d = avl_readdata;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [31:0] d;

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_cmd_valid", 128'(cmd_valid), 128'(0));
    check_eq("rst_readdatavalid", 128'(avl_readdatavalid), 128'(0));
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    rd(4'd3, d); check_eq("rst_status", 128'(d), 128'(0));
    rd(4'd0, d); check_eq("debug_size", 128'(d), 128'h8f4);

    // Basic command with delayed ready and response.
    wr(4'd4, 32'h1234);
    wr(4'd2, 32'd5);
    steps(2);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    steps(9);
    rsp_valid = 1'b1; rsp_code = 8'd0; rsp_data = 32'hCAFE; step(); rsp_valid = 1'b0;
    check_eq("t1_code", 128'(cmd_code), 128'd5);
    check_eq("t1_param0", 128'(cmd_params[31:0]), 128'h1234);
    rd(4'd3, d); check_eq("t1_status", 128'(d), 128'h2);
    rd(4'd1, d); check_eq("t1_rsp_data", 128'(d), 128'hCAFE);
    check_eq("t1_busy", 128'(busy), 128'd0);

    // Out-of-range command code.
    wr(4'd2, 32'd22);
    cmd_ready = 1'b1; steps(3); cmd_ready = 1'b0;
    check_eq("t2_no_valid", 128'(cmd_valid), 128'd0);
    rd(4'd3, d); check_eq("t2_status", 128'(d), 128'h13);
    wr(4'd2, 32'd0);
    rd(4'd3, d); check_eq("t2_idle", 128'(d), 128'h0);

    // Timeout exactly TO cycles after the handshake.
    wr(4'd2, 32'd7);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    steps(TO - 1);
    check_eq("t3_busy_before", 128'(busy), 128'd1);
    step();
    check_eq("t3_busy_after", 128'(busy), 128'd0);
    rd(4'd3, d); check_eq("t3_status", 128'(d), 128'h23);
    // Response on the expiry cycle wins.
    wr(4'd2, 32'd7);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    steps(TO - 1);
    rsp_valid = 1'b1; rsp_data = 32'h55; step(); rsp_valid = 1'b0;
    rd(4'd3, d); check_eq("t3_race_status", 128'(d), 128'h2);

    // Core error, then reissue from ERROR.
    wr(4'd2, 32'd9);
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    rsp_valid = 1'b1; rsp_code = 8'h7; step(); rsp_valid = 1'b0; rsp_code = 8'h0;
    rd(4'd3, d); check_eq("t4_status", 128'(d), 128'h733);
    wr(4'd2, 32'd4);
    check_eq("t4_reissue_valid", 128'(cmd_valid), 128'd1);
    rd(4'd3, d); check_eq("t4_cleared", 128'(d), 128'h1);

    // Writes dropped while busy.
    cmd_ready = 1'b1; step(); cmd_ready = 1'b0;
    wr(4'd2, 32'd3);
    wr(4'd2, 32'd3);
    wr(4'd4, 32'hFFFF);
    rd(4'd4, d); check_eq("t5_param_kept", 128'(d), 128'h1234);
    check_eq("t5_code_kept", 128'(cmd_code), 128'd4);
    rd(4'd3, d); check_eq("t5_drop", 128'(d[31:16]), 128'd2);
    rsp_valid = 1'b1; step(); rsp_valid = 1'b0;

    // Asynchronous reset in the middle of ISSUE.
    wr(4'd2, 32'd5);
    check_eq("t6_valid_pre", 128'(cmd_valid), 128'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("t6_valid", 128'(cmd_valid), 128'd0);
    check_eq("t6_busy", 128'(busy), 128'd0);
    check_eq("t6_code", 128'(cmd_code), 128'd0);
    check_eq("t6_params", 128'(cmd_params), 128'd0);
    check_eq("t6_readdata", 128'(avl_readdata), 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    rd(4'd3, d); check_eq("t6_status", 128'(d), 128'd0);
    rd(4'd1, d); check_eq("t6_rsp_data", 128'(d), 128'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int r;
      avl_write = ($urandom % 6) == 0;
      avl_read  = !avl_write && (($urandom % 3) == 0);
      r = int'($urandom % 8);
      if (avl_write) begin
        avl_address = (r < 3) ? 4'd2 : (r < 6) ? 4'(4 + $urandom % NP) : 4'($urandom % 16);
        if (avl_address == 4'd2) begin
          case ($urandom % 8)
            0:       avl_writedata = 32'd0;
            1:       avl_writedata = 32'(22 + $urandom % 234);
            2:       avl_writedata = $urandom;
            default: avl_writedata = 32'(1 + $urandom % 21);
          endcase
        end else begin
          avl_writedata = $urandom;
        end
      end else begin
        avl_address = 4'($urandom % 12);
      end
      cmd_ready = ($urandom % 2) == 0;
      rsp_valid = ($urandom % 10) == 0;
      rsp_code  = (($urandom % 4) == 0) ? 8'($urandom) : 8'd0;
      rsp_data  = $urandom;
      step();
    end
    avl_write = 1'b0; avl_read = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
